// File: rtl/noc_weighted_rr_arbiter.sv
// Weighted round-robin arbiter: zero-latency one-hot grant, per-requester consecutive-grant
// quota, optional grant lock until the holder signals free.
module noc_weighted_rr_arbiter #(
    parameter int unsigned REQUESTS     = 4,
    parameter int unsigned WEIGHT_WIDTH = 4,
    parameter int unsigned KEEP_RESULT  = 1,
    parameter int unsigned INITIAL_PTR  = REQUESTS - 1,
    localparam int unsigned IW          = (REQUESTS > 1) ? $clog2(REQUESTS) : 1
) (
    input  logic                             noc_clk,
    input  logic                             noc_rst_n,
    input  logic [REQUESTS-1:0]              request,
    input  logic [REQUESTS-1:0]              free,
    input  logic [REQUESTS*WEIGHT_WIDTH-1:0] weight,
    output logic [REQUESTS-1:0]              o_grant,
    output logic                             o_grant_valid,
    output logic [IW-1:0]                    o_grant_index
);

    logic                    busy_q, busy_d;
    logic [IW-1:0]           ptr_q, ptr_d;
    logic [WEIGHT_WIDTH-1:0] cnt_q, cnt_d;

    logic                    grab;
    logic                    stay;
    logic                    found;
    logic [IW-1:0]           search_idx;
    logic [IW-1:0]           winner;
    logic [IW-1:0]           grant_idx;
    logic                    grant_vld;
    logic [WEIGHT_WIDTH-1:0] win_weight;
    int unsigned             cand;

    // Search order: ptr+1, ptr+2, ... wrapping, with ptr itself scanned last.
    always_comb begin
        found      = 1'b0;
        search_idx = ptr_q;
        cand       = 0;
        for (int unsigned i = 1; i <= REQUESTS; i++) begin
            cand = (32'(ptr_q) + i) % REQUESTS;
            if (!found && request[cand]) begin
                found      = 1'b1;
                search_idx = IW'(cand);
            end
        end
    end

    always_comb begin
        grab       = !busy_q && (|request);
        stay       = request[ptr_q] && (cnt_q != '0);
        winner     = stay ? ptr_q : search_idx;
        win_weight = weight[32'(winner)*WEIGHT_WIDTH +: WEIGHT_WIDTH];

        grant_vld  = busy_q || grab;
        grant_idx  = grant_vld ? (busy_q ? ptr_q : winner) : '0;
    end

    always_comb begin
        o_grant = '0;
        for (int unsigned i = 0; i < REQUESTS; i++) begin
            o_grant[i] = grant_vld && (grant_idx == IW'(i));
        end
        o_grant_valid = grant_vld;
        o_grant_index = grant_idx;
    end

    always_comb begin
        busy_d = busy_q;
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        if (busy_q) begin
            if (free[ptr_q]) begin
                busy_d = 1'b0;
            end
        end else if (grab) begin
            ptr_d = winner;
            if (stay) begin
                cnt_d = cnt_q - WEIGHT_WIDTH'(1);
            end else begin
                // A zero weight behaves as one: the reload becomes zero either way.
                cnt_d = (win_weight == '0) ? '0 : win_weight - WEIGHT_WIDTH'(1);
            end
            busy_d = (KEEP_RESULT != 0) && !free[winner];
        end
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            busy_q <= 1'b0;
            ptr_q  <= IW'(INITIAL_PTR);
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_noc_weighted_rr_arbiter.sv
// Directed bench for noc_weighted_rr_arbiter: a locking instance and a non-locking instance,
// with hand-computed grant sequences.
module tb_noc_weighted_rr_arbiter;

    logic        noc_clk;
    logic        noc_rst_n;
    logic [3:0]  request, free;
    logic [15:0] weight;
    logic [3:0]  o_grant;
    logic        o_grant_valid;
    logic [1:0]  o_grant_index;

    logic [3:0]  req_b, free_b;
    logic [3:0]  grant_b;
    logic        valid_b;
    logic [1:0]  index_b;

    int n_cmp = 0;
    int n_err = 0;

    noc_weighted_rr_arbiter #(
        .REQUESTS    (4),
        .WEIGHT_WIDTH(4),
        .KEEP_RESULT (1),
        .INITIAL_PTR (3)
    ) u_dut (
        .noc_clk      (noc_clk),
        .noc_rst_n    (noc_rst_n),
        .request      (request),
        .free         (free),
        .weight       (weight),
        .o_grant      (o_grant),
        .o_grant_valid(o_grant_valid),
        .o_grant_index(o_grant_index)
    );

    noc_weighted_rr_arbiter #(
        .REQUESTS    (4),
        .WEIGHT_WIDTH(4),
        .KEEP_RESULT (0),
        .INITIAL_PTR (3)
    ) u_dut_nokeep (
        .noc_clk      (noc_clk),
        .noc_rst_n    (noc_rst_n),
        .request      (req_b),
        .free         (free_b),
        .weight       (16'h1111),
        .o_grant      (grant_b),
        .o_grant_valid(valid_b),
        .o_grant_index(index_b)
    );

    initial begin
        noc_clk = 1'b0;
        forever #5 noc_clk = ~noc_clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        idx_of = g[1] ? 2'd1 : g[2] ? 2'd2 : g[3] ? 2'd3 : 2'd0;
    endfunction

    task automatic chk_a(input string tag, input logic [3:0] eg);
        check_eq({tag, ".grant"}, 32'(o_grant), 32'(eg));
        check_eq({tag, ".valid"}, 32'(o_grant_valid), 32'(|eg));
        check_eq({tag, ".index"}, 32'(o_grant_index), 32'(idx_of(eg)));
    endtask

    task automatic chk_b(input string tag, input logic [3:0] eg);
        check_eq({tag, ".grant"}, 32'(grant_b), 32'(eg));
        check_eq({tag, ".valid"}, 32'(valid_b), 32'(|eg));
        check_eq({tag, ".index"}, 32'(index_b), 32'(idx_of(eg)));
    endtask

    // Inputs change at posedge+1; combinational outputs are sampled at posedge+4.
    task automatic next_cycle();
        @(posedge noc_clk);
        #1;
    endtask

    task automatic do_reset();
        noc_rst_n = 1'b0;
        #3;
        noc_rst_n = 1'b1;
        next_cycle();
    endtask

    initial begin : stim
        int seq [10] = '{0, 1, 1, 2, 2, 2, 3, 0, 1, 1};
        noc_rst_n = 1'b0;
        request   = '0;
        free      = '0;
        weight    = 16'h1111;
        req_b     = '0;
        free_b    = '0;
        #1;
        chk_a("reset", 4'b0000);
        chk_b("reset_b", 4'b0000);
        next_cycle();
        do_reset();

        // Plain rotation, all weights 1, single-cycle packets.
        request = 4'b1111;
        free    = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #3;
            chk_a($sformatf("rot%0d", i), 4'b0001 << (i % 4));
            next_cycle();
        end
        request = '0;
        #3;
        chk_a("idle", 4'b0000);
        next_cycle();

        // Weighted sequence {1,2,3,1}.
        do_reset();
        weight  = 16'h1321;
        request = 4'b1111;
        free    = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            #3;
            chk_a($sformatf("wrr%0d", i), 4'b0001 << seq[i]);
            next_cycle();
        end

        // Lock until free[holder]; foreign free bit ignored.
        request = '0;
        do_reset();
        weight = 16'h1111;
        free   = 4'b0000;
        for (int c = 1; c <= 7; c++) begin
            request = (c <= 2) ? 4'b0010 : 4'b0000;
            free    = (c == 4) ? 4'b0001 : (c == 6) ? 4'b0010 : 4'b0000;
            #3;
            chk_a($sformatf("lock%0d", c), (c <= 6) ? 4'b0010 : 4'b0000);
            next_cycle();
        end

        // Credit forfeit, then a fresh quota of 3 on re-raise.
        do_reset();
        weight  = 16'h1131;
        free    = 4'b1111;
        request = 4'b0010;
        #3; chk_a("forf0", 4'b0010); next_cycle();
        request = 4'b0100;
        #3; chk_a("forf1", 4'b0100); next_cycle();
        request = 4'b0010;
        #3; chk_a("forf2", 4'b0010); next_cycle();
        request = 4'b0110;
        #3; chk_a("forf3", 4'b0010); next_cycle();
        #3; chk_a("forf4", 4'b0010); next_cycle();
        #3; chk_a("forf5", 4'b0100); next_cycle();

        // Weight 0 acts as 1: no lingering credit after the grabs.
        do_reset();
        weight  = 16'h1011;
        free    = 4'b1111;
        request = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            #3;
            chk_a($sformatf("w0_%0d", i), 4'b0100);
            next_cycle();
        end
        request = 4'b0110;
        #3; chk_a("w0_rot", 4'b0010); next_cycle();

        // Asynchronous reset while a grant is held.
        do_reset();
        weight  = 16'h1111;
        free    = 4'b0000;
        request = 4'b1000;
        #3; chk_a("busy0", 4'b1000); next_cycle();
        request = 4'b0000;
        #3; chk_a("busy1", 4'b1000);
        #1;
        noc_rst_n = 1'b0;
        #1;
        chk_a("async_rst", 4'b0000);
        #1;
        noc_rst_n = 1'b1;
        next_cycle();
        request = 4'b1111;
        free    = 4'b1111;
        #3; chk_a("post_rst", 4'b0001); next_cycle();
        request = '0;

        // Non-locking instance: free held low, grants alternate every cycle.
        do_reset();
        free_b = 4'b0000;
        req_b  = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            #3;
            chk_b($sformatf("nokeep%0d", i), (i % 2 == 0) ? 4'b0001 : 4'b0010);
            next_cycle();
        end
        req_b = '0;
        #3; chk_b("nokeep_idle", 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/noc_weighted_rr_arbiter.md
# noc_weighted_rr_arbiter

Weighted round-robin arbiter for NoC router output ports and virtual-channel allocation. Each requester may hold up to a programmable number of back-to-back grants (its weight) before the grant moves on. The grant is zero-latency and can be locked until the granted packet signals completion. It generalises the plain round-robin arbiter in three ways: per-requester weights, a binary grant index output and a grant-valid output.

## Interface
- REQUESTS, 4: number of requesters, ≥2.
- WEIGHT_WIDTH, 4: width of each weight field.
- KEEP_RESULT, 1: 1 holds the grant until `free`; 0 re-arbitrates every cycle.
- INITIAL_PTR, REQUESTS-1: index of the last holder after reset. The first search starts at INITIAL_PTR+1 (mod REQUESTS).
- IW, derived: max(1, $clog2(REQUESTS)).

Ports:
- noc_clk  in  1  clock.
- noc_rst_n  in  1  reset; asynchronous, active-low.
- request  in  REQUESTS  per-requester request.
- free  in  REQUESTS  per-requester end-of-packet / release. Only the bit of the current holder is observed.
- weight  in  REQUESTS×WEIGHT_WIDTH  consecutive-grant quota per requester. Quasi-static; sampled at grab. A value of 0 is treated as 1.
- o_grant  out  REQUESTS  one-hot grant, or all-zero.
- o_grant_valid  out  1  |o_grant.
- o_grant_index  out  IW  binary index of the granted requester; 0 when o_grant_valid=0.

## Operation
State:
- `busy` (1b).
- `ptr` (IW): index of the last holder.
- `cnt` (WEIGHT_WIDTH): extra consecutive grants remaining for `ptr`.

Reset values: busy=0, ptr=INITIAL_PTR, cnt=0. All outputs are 0 while no request is present.

Arbitration cycle:
- Occurs when busy=0 and |request=1; this is a "grab".
- Winner selection:
  - Stay: if request[ptr]=1 and cnt>0, the winner is ptr.
  - Search: otherwise, the winner is the first set request bit scanning ptr+1, ptr+2, … wrapping, with ptr itself scanned last.
- o_grant = onehot(winner) in the same cycle (combinational).
- At the clock edge:
  - ptr ← winner.
  - cnt ← cnt−1 on stay; cnt ← max(weight[winner],1)−1 on search.
  - busy ← 1, if KEEP_RESULT=1 and free[winner]=0 in the grab cycle.
  - busy stays 0 if free[winner]=1 in the grab cycle (single-cycle packet).

Busy state (KEEP_RESULT=1 only):
- o_grant = onehot(ptr), held independent of `request`.
- Dropping the request while busy does not remove the grant.
- free[ptr]=1 → busy ← 0 at the edge. The grant is still asserted in that cycle.
- The next cycle arbitrates normally, so back-to-back packets see a continuous grant.
- free bits of non-holders are ignored. cnt and ptr are unchanged while busy.

Other rules:
- Credit forfeit: if the holder deasserts its request while cnt>0, the next grab searches from ptr+1. Remaining credit is discarded on that search, because cnt is overwritten.
- KEEP_RESULT=0: busy is tied 0. Every cycle with |request=1 is a grab, and `free` is ignored.
- Idle (busy=0, request=0): outputs are 0 and state holds.
- Asynchronous reset mid-packet: outputs drop to 0 immediately and state returns to reset values.

## Timing
- Grant latency: 0 cycles from `request` in an arbitration cycle. There is a combinational path request→o_grant/o_grant_index.
- State updates on the rising noc_clk edge only.
- Release-to-regrant: the first arbitration happens in the cycle after the one where free[ptr]=1.
- Weight w with continuous request and single-cycle packets gives exactly w consecutive grants, then the grant rotates.
- Fairness: any asserted request is granted within (REQUESTS−1) other holder tenures.

## Test plan
- Reset/rotate: REQUESTS=4, INITIAL_PTR=3, all weights 1, request=4'b1111, free=4'b1111 constant → grants 0001, 0010, 0100, 1000, 0001; o_grant_index 0,1,2,3,0; o_grant_valid=1 each cycle. With request=0, all outputs are 0.
- Weights {w0..w3}={1,2,3,1}, all requesting, free=1111 → holder sequence 0,1,1,2,2,2,3,0,1,1.
- Lock: request=0010 for 2 cycles then 0000, free low for 5 cycles, free[1]=1 in cycle 6 → o_grant=0010 in cycles 1–6, 0000 in cycle 7. free[0]=1 while busy has no effect.
- Credit forfeit: w1=3, req1 granted once, req1 drops, request=0100 → next grab grants 0100. Re-raising req1 later gets a fresh quota of 3.
- Weight 0: w2=0, only req2 asserted, free=1111 → grant 0100 every cycle, with cnt reloading to 0 each grab.
- Async reset mid-busy with grant 1000 held → o_grant=0, valid=0 immediately. After release, request=1111 → first grant 0001 (INITIAL_PTR=3). KEEP_RESULT=0 variant: free held 0, request=0011 → grants alternate 0001/0010 every cycle.
